// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Ports: clk, reset_n (async active-low), start, flush, op[1:0] (funct3[1:0]:
//   0=MUL 1=MULH 2=MULHSU 3=MULHU), a/b (rs1/rs2), busy, done (1-cycle pulse),
//   result (registered, held until the next done).
// Optional feature: define MUL_EARLY_OUT_EN to leave CALC as soon as the
//   remaining multiplier bits are all zero (variable latency).
module mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [1:0] MUL_MUL    = 2'd0;
    localparam logic [1:0] MUL_MULH   = 2'd1;
    localparam logic [1:0] MUL_MULHSU = 2'd2;
    localparam logic [1:0] MUL_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t next_state;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplr;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic [1:0]        op_q;

    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              last;
    logic [2*XLEN-1:0] acc_add;
    logic [2*XLEN-1:0] prod;

    // Operand signedness by opcode.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (op)
            MUL_MULH: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            MUL_MULHSU: a_sgn = 1'b1;
            MUL_MUL,
            MUL_MULHU: ;
            default: ;
        endcase
    end

    // Negating -2^(XLEN-1) wraps to 2^(XLEN-1), which is the correct
    // magnitude once it is treated as unsigned.
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

`ifdef MUL_EARLY_OUT_EN
    // Stop once the bits still to be consumed are all zero.
    assign last = (cnt == CNT_LAST) || ((mplr >> 1) == '0);
`else
    assign last = (cnt == CNT_LAST);
`endif

    // mcand is pre-shifted each step, so it already equals |a| << cnt.
    assign acc_add = mplr[0] ? acc + mcand : acc;
    assign prod    = neg ? -acc : acc;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over both acceptance and completion.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) next_state = CALC;
                CALC: if (last) next_state = FIX;
                FIX:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            op_q   <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        acc   <= '0;
                        mcand <= {{XLEN{1'b0}}, a_mag};
                        mplr  <= b_mag;
                        cnt   <= '0;
                        neg   <= a_neg ^ b_neg;
                        op_q  <= op;
                    end
                end
                CALC: begin
                    acc   <= acc_add;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (op_q == MUL_MUL) begin
                            result <= prod[XLEN-1:0];
                        end else begin
                            result <= prod[2*XLEN-1:XLEN];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
